// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and MEM.
// The slave modport is the arbiter's view; the master modport is the
// requester/memory side that drives requests and MFC.
interface mem_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       MFC;
  logic       MEM_EN;
  logic       MEM_RW;
  logic       timeout;
  logic       busy;

  modport slave (
    input  req,
    input  MFC,
    output gnt,
    output done,
    output MEM_EN,
    output MEM_RW,
    output timeout,
    output busy
  );

  modport master (
    output req,
    output MFC,
    input  gnt,
    input  done,
    input  MEM_EN,
    input  MEM_RW,
    input  timeout,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for three memory requesters (fetch, load, store).
// One transaction walks IDLE -> GRANT -> ACCESS -> DONE. All outputs are
// registered and derived from the next state, so they change on the same
// edge as the state they describe. An ACCESS that sees no MFC within
// TIMEOUT cycles is closed with done plus a timeout pulse.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last ACCESS cycle before the abort fires, and the saturation ceiling.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0]       IDX_ST   = 2'd2;

  state_t           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       done_q, done_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic             to_q, to_d;
  logic             busy_q, busy_d;

  // Index to one-hot requester vector.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Round-robin pick: search begins just after the last winner and wraps
  // 2 -> 0. Only called with a non-zero request vector.
  function automatic logic [1:0] rr_pick(input logic [2:0] r,
                                         input logic [1:0] last);
    logic [1:0] a, b, c;
    case (last)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (|(r & onehot(a)))      rr_pick = a;
    else if (|(r & onehot(b))) rr_pick = b;
    else                       rr_pick = c;
  endfunction

  // Next-state, winner latch, timeout counter and next output values.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req != 3'b000) begin
          win_d   = rr_pick(bus.req, last_q);
          last_d  = win_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // MFC wins over an abort landing on the same edge.
        if (bus.MFC) begin
          state_d = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    gnt_d  = (state_d != IDLE) ? onehot(win_d) : 3'b000;
    done_d = (state_d == DONE) ? onehot(win_d) : 3'b000;
    en_d   = (state_d == ACCESS);
    rw_d   = (state_d == ACCESS) && (win_d == IDX_ST);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.MEM_EN  = en_q;
  assign bus.MEM_RW  = rw_q;
  assign bus.timeout = to_q;
  assign bus.busy    = busy_q;

endmodule
